multicycle_alu: RTL and testbench

Execution unit that consumes the 4-bit ALU_Control code produced by the ALU control decoder. It performs the selected operation on two operands.
- Logic, arithmetic and compare ops complete in a fixed 2 cycles.
- Shifts run iteratively, one bit per cycle, to keep the barrel shifter out of the datapath.
- A Start/Busy/Done handshake lets the multi-cycle datapath stall the EX stage while a result is pending.

---
 rtl/multicycle_alu.sv | 155 +++++++++++++++
 tb/tb_multicycle_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU execution unit.
// Logic, arithmetic and compare ops finish in two cycles; shifts iterate one bit
// per cycle through the latched B operand so no barrel shifter is needed.
// Start/Busy/Done handshake: Start is sampled only in IDLE, Done pulses in FIN.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [3:0]         ALU_Control,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Overflow,
  output logic               IllegalOp
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opA_q, opA_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   sum, diff, shiftVal;
  logic [WIDTH-1:0]   execResult;
  logic               execOvf, execIllegal;

  assign sum      = opA_q + opB_q;
  assign diff     = opA_q - opB_q;
  assign shiftVal = (op_q == 4'd3) ? {opB_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, opB_q[WIDTH-1:1]};

  // Single-step result of the latched op; shift codes only get here with Shamt=0.
  always_comb begin
    execResult  = '0;
    execOvf     = 1'b0;
    execIllegal = 1'b0;
    case (op_q)
      4'd1: begin
        execResult = sum;
        execOvf    = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                     (sum[WIDTH-1] != opA_q[WIDTH-1]);
      end
      4'd2: begin
        execResult = diff;
        execOvf    = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) &&
                     (diff[WIDTH-1] != opA_q[WIDTH-1]);
      end
      4'd3, 4'd4: execResult = opB_q;
      4'd5: execResult = opA_q & opB_q;
      4'd6: execResult = opA_q | opB_q;
      4'd7: execResult = ~(opA_q | opB_q);
      4'd8: execResult = {{(WIDTH-1){1'b0}}, (opA_q < opB_q)};
      4'd9: execResult = {{(WIDTH-1){1'b0}}, ($signed(opA_q) < $signed(opB_q))};
      default: execIllegal = 1'b1;
    endcase
  end

  // Next-state, operand latching, shift iteration and completion write-back.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    op_d      = op_q;
    count_d   = count_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          opA_d   = A;
          opB_d   = B;
          op_d    = ALU_Control;
          count_d = Shamt;
          if ((ALU_Control == 4'd3 || ALU_Control == 4'd4) && (Shamt != '0))
            state_d = SHIFT;
          else
            state_d = EXEC;
        end
      end
      EXEC: begin
        Busy      = 1'b1;
        result_d  = execResult;
        zero_d    = (execResult == '0);
        ovf_d     = execOvf;
        illegal_d = execIllegal;
        state_d   = FIN;
      end
      SHIFT: begin
        Busy    = 1'b1;
        opB_d   = shiftVal;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d  = shiftVal;
          zero_d    = (shiftVal == '0);
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
          state_d   = FIN;
        end
      end
      FIN: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      op_q      <= '0;
      count_q   <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      op_q      <= op_d;
      count_q   <= count_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: the driver pushes expected results and
// checks latency/Busy; an independent monitor pops and compares on every Done.
module tb_multicycle_alu;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [3:0]  ALU_Control;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        IllegalOp;

  exp_t  expQ[$];
  string nameQ[$];
  int    compared   = 0;
  int    mismatched = 0;

  multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .ALU_Control(ALU_Control),
    .A          (A),
    .B          (B),
    .Shamt      (Shamt),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .Zero       (Zero),
    .Overflow   (Overflow),
    .IllegalOp  (IllegalOp)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Done) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected Done: got Result=0x%08h with no op outstanding", Result);
      end else begin
        exp_t  e;
        string n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        if ({Result, Zero, Overflow, IllegalOp} !== e) begin
          mismatched++;
          $display("[TB] FAIL %s: got R=0x%08h Z=%0b V=%0b I=%0b, expected R=0x%08h Z=%0b V=%0b I=%0b",
                   n, Result, Zero, Overflow, IllegalOp, e.result, e.zero, e.ovf, e.ill);
        end
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] code, input logic [4:0] sh,
                               input logic [31:0] expRes, input logic expZero,
                               input logic expOvf, input logic expIll,
                               input int expLat, input bit holdStart);
    exp_t e;
    int   edges;
    int   busyCycles;
    bit   timedOut;
    @(negedge clk);
    A = a; B = b; ALU_Control = code; Shamt = sh; Start = 1'b1;
    e.result = expRes; e.zero = expZero; e.ovf = expOvf; e.ill = expIll;
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clk);
    edges = 1;
    busyCycles = 0;
    timedOut = 1'b0;
    #1;
    if (!holdStart) Start = 1'b0;
    A = $urandom; B = $urandom; ALU_Control = 4'($urandom_range(0, 15)); Shamt = 5'($urandom);
    forever begin
      @(negedge clk);
      if (Done) break;
      if (Busy) busyCycles++;
      if (edges >= 100) begin
        timedOut = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    Start = 1'b0;
    if (timedOut) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: got no Done within %0d edges, expected Done after edge %0d",
               name, edges, expLat);
    end else begin
      checkOutput({name, " latency"}, 32'(edges), 32'(expLat));
      checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expLat - 1));
      checkOutput({name, " busy at done"}, {31'd0, Busy}, 32'd0);
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; ALU_Control = 4'd0; A = '0; B = '0; Shamt = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset Result", Result, 32'd0);
    checkOutput("reset flags", {26'd0, Busy, Done, Zero, Overflow, IllegalOp, 1'b0}, 32'd0);
    rst_n = 1'b1;

    applyStimulus("add ovf",  32'h7FFFFFFF, 32'h00000001, 4'd1, 5'd0, 32'h80000000, 0, 1, 0, 2, 0);
    applyStimulus("sub eq",   32'h12345678, 32'h12345678, 4'd2, 5'd0, 32'h00000000, 1, 0, 0, 2, 0);
    applyStimulus("nor zero", 32'h00000000, 32'h00000000, 4'd7, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 2, 0);
    applyStimulus("sll 31",   32'h00000000, 32'h00000001, 4'd3, 5'd31, 32'h80000000, 0, 0, 0, 32, 0);
    applyStimulus("srl 4",    32'h00000000, 32'h80000000, 4'd4, 5'd4, 32'h08000000, 0, 0, 0, 5, 0);
    applyStimulus("srl 0",    32'h00000000, 32'hDEADBEEF, 4'd4, 5'd0, 32'hDEADBEEF, 0, 0, 0, 2, 0);
    applyStimulus("slt",      32'hFFFFFFFF, 32'h00000001, 4'd9, 5'd0, 32'h00000001, 0, 0, 0, 2, 0);
    applyStimulus("sltu",     32'hFFFFFFFF, 32'h00000001, 4'd8, 5'd0, 32'h00000000, 1, 0, 0, 2, 0);
    applyStimulus("sll held", 32'h00000000, 32'h000000FF, 4'd3, 5'd8, 32'h0000FF00, 0, 0, 0, 9, 1);
    repeat (4) @(negedge clk);
    checkOutput("no queued op busy", {31'd0, Busy}, 32'd0);
    applyStimulus("illegal 12", 32'h11111111, 32'h22222222, 4'd12, 5'd3, 32'h00000000, 1, 0, 1, 2, 0);
    applyStimulus("and",      32'hF0F0F0F0, 32'hFF00FF00, 4'd5, 5'd0, 32'hF000F000, 0, 0, 0, 2, 0);
    applyStimulus("or",       32'h0000000F, 32'h000000F0, 4'd6, 5'd0, 32'h000000FF, 0, 0, 0, 2, 0);
    applyStimulus("sub ovf",  32'h80000000, 32'h00000001, 4'd2, 5'd0, 32'h7FFFFFFF, 0, 1, 0, 2, 0);

    // Reset in the middle of a long shift: the op is dropped with no Done.
    @(negedge clk);
    A = 32'h0; B = 32'hFFFF0000; ALU_Control = 4'd4; Shamt = 5'd20; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-shift busy", {31'd0, Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort Result", Result, 32'd0);
    checkOutput("abort flags", {27'd0, Busy, Done, Zero, Overflow, IllegalOp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("post-abort Result", Result, 32'd0);
    checkOutput("post-abort flags", {27'd0, Busy, Done, Zero, Overflow, IllegalOp}, 32'd0);

    applyStimulus("add after reset", 32'h00000002, 32'h00000003, 4'd1, 5'd0, 32'h00000005, 0, 0, 0, 2, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
